// File: rtl/cmos_frame_packer_if.sv
// Sensor timing input and DDR3 write-FIFO bus of the CMOS frame packer.
// master: the packer (consumes sensor signals, drives FIFO writes).
// slave : the sensor timing generator / FIFO side.
interface cmos_frame_packer_if #(
  parameter int PIX_W  = 10,
  parameter int WORD_W = 64
) ();
  logic              fval;
  logic              lval;
  logic [PIX_W-1:0]  pix_data;
  logic              wr_full;
  logic              wr_en;
  logic [WORD_W-1:0] wr_data;

  modport master (
    input  fval, lval, pix_data, wr_full,
    output wr_en, wr_data
  );

  modport slave (
    output fval, lval, pix_data, wr_full,
    input  wr_en, wr_data
  );
endinterface

// File: rtl/cmos_frame_packer.sv
// Receives fval/lval framed pixels, packs LANES pixels per word for the DDR3
// write FIFO and checks line/frame geometry against the programmed window.
// Optional feature macro: TEST_PATTERN_EN replaces pix_data with a generated
// {frame LSB, line_cnt[3:0], pix_cnt[4:0]} pattern.
//
//  state   | meaning
//  S_IDLE  | between frames, waiting for fval rise
//  S_FRAME | inside frame, between lines
//  S_LINE  | capturing pixels of a line
//  S_DONE  | final line flush in flight, frame_done follows
module cmos_frame_packer #(
  parameter int PIX_W  = 10,
  parameter int LANE_W = 16,
  parameter int LANES  = 4
) (
  input  logic        clk_rxg,
  input  logic        rst_rx,
  cmos_frame_packer_if.master bus,
  input  logic [11:0] window_row_length,
  input  logic [10:0] line_pix_length,
  output logic        frame_start,
  output logic        frame_done,
  output logic [11:0] line_cnt,
  output logic        err_line_len,
  output logic        err_frame_len,
  output logic        err_overflow
);
  localparam int WORD  = LANES * LANE_W;
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_LINE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               fval_q, lval_q, fval_prev_q;
  logic [PIX_W-1:0]   pix_q;
  logic [IDX_W-1:0]   lane_q, lane_d;
  logic [WORD-1:0]    buf_q, buf_d;
  logic [10:0]        pix_cnt_q, pix_cnt_d;
  logic [11:0]        line_cnt_q, line_cnt_d;
  logic               push_q, push_d;
  logic [WORD-1:0]    word_q, word_d;
  logic [WORD-1:0]    last_q, last_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_done_q, frame_done_d;
  logic               err_line_q, err_line_d;
  logic               err_frame_q, err_frame_d;
  logic               err_ovf_q, err_ovf_d;
  logic               frame_tog_q, frame_tog_d;
  logic               wr_en_int;
  logic               cap, first;
  logic [10:0]        cap_idx;
  logic [PIX_W-1:0]   cap_pix;
  logic [WORD-1:0]    tmp_buf;
  logic [11:0]        line_inc;

  // A push is lost (not delayed) when the FIFO is full on the push cycle.
  assign wr_en_int   = push_q & ~bus.wr_full;
  assign bus.wr_en   = wr_en_int;
  assign bus.wr_data = wr_en_int ? word_q : last_q;

  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign line_cnt      = line_cnt_q;
  assign err_line_len  = err_line_q;
  assign err_frame_len = err_frame_q;
  assign err_overflow  = err_ovf_q;

  assign line_inc = (line_cnt_q == 12'hFFF) ? line_cnt_q : line_cnt_q + 12'd1;

  // Next-state, packing and geometry checks.
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    buf_d         = buf_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    push_d        = 1'b0;
    word_d        = word_q;
    last_d        = wr_en_int ? word_q : last_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    err_line_d    = err_line_q;
    err_frame_d   = err_frame_q;
    err_ovf_d     = err_ovf_q;
    frame_tog_d   = frame_tog_q;
    cap           = 1'b0;
    first         = 1'b0;
    tmp_buf       = buf_q;

    case (state_q)
      S_IDLE: begin
        if (fval_q && !fval_prev_q) begin
          frame_start_d = 1'b1;
          line_cnt_d    = '0;
          err_line_d    = 1'b0;
          err_frame_d   = 1'b0;
          err_ovf_d     = 1'b0;
          frame_tog_d   = ~frame_tog_q;
          state_d       = S_FRAME;
        end
      end
      S_FRAME: begin
        if (!fval_q) begin
          frame_done_d = 1'b1;
          if (line_cnt_q != window_row_length) err_frame_d = 1'b1;
          state_d = S_IDLE;
        end else if (lval_q) begin
          cap     = 1'b1;
          first   = 1'b1;
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        if (lval_q && fval_q) begin
          cap = 1'b1;
        end else begin
          if (lane_q != '0) begin
            push_d = 1'b1;
            word_d = buf_q;
            buf_d  = '0;
            lane_d = '0;
          end
          if (pix_cnt_q != line_pix_length) err_line_d = 1'b1;
          line_cnt_d = line_inc;
          if (!fval_q) begin
            // Frame end waits for the line flush so frame_done trails wr_en.
            if (lane_q != '0) begin
              state_d = S_DONE;
            end else begin
              frame_done_d = 1'b1;
              if (line_inc != window_row_length) err_frame_d = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_FRAME;
          end
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        if (line_cnt_q != window_row_length) err_frame_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cap_idx = first ? 11'd0 : pix_cnt_q;
`ifdef TEST_PATTERN_EN
    cap_pix = {frame_tog_q, line_cnt_q[3:0], cap_idx[4:0]};
`else
    cap_pix = pix_q;
`endif

    if (cap) begin
      pix_cnt_d = first ? 11'd1 : ((pix_cnt_q == 11'h7FF) ? pix_cnt_q : pix_cnt_q + 11'd1);
      tmp_buf[lane_q*LANE_W +: LANE_W] = {{(LANE_W-PIX_W){1'b0}}, cap_pix};
      if (lane_q == IDX_W'(LANES-1)) begin
        push_d = 1'b1;
        word_d = tmp_buf;
        buf_d  = '0;
        lane_d = '0;
      end else begin
        buf_d  = tmp_buf;
        lane_d = lane_q + IDX_W'(1);
      end
    end

    if (push_q && bus.wr_full) err_ovf_d = 1'b1;
  end

  // Input registers and all state flops.
  always_ff @(posedge clk_rxg or posedge rst_rx) begin
    if (rst_rx) begin
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      fval_prev_q   <= 1'b0;
      pix_q         <= '0;
      state_q       <= S_IDLE;
      lane_q        <= '0;
      buf_q         <= '0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      push_q        <= 1'b0;
      word_q        <= '0;
      last_q        <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
      frame_tog_q   <= 1'b0;
    end else begin
      fval_q        <= bus.fval;
      lval_q        <= bus.lval;
      fval_prev_q   <= fval_q;
      pix_q         <= bus.pix_data;
      state_q       <= state_d;
      lane_q        <= lane_d;
      buf_q         <= buf_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      push_q        <= push_d;
      word_q        <= word_d;
      last_q        <= last_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      err_line_q    <= err_line_d;
      err_frame_q   <= err_frame_d;
      err_ovf_q     <= err_ovf_d;
      frame_tog_q   <= frame_tog_d;
    end
  end
endmodule
